// File: rtl/clk_run_ctrl_pkg.sv
// clk_run_ctrl_pkg: mode encodings and default speed table for the CPU run/step/halt controller.
package clk_run_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_HALT     = 2'b00,
    MODE_RUN      = 2'b01,
    MODE_STEP     = 2'b10,
    MODE_WAIT_REL = 2'b11
  } mode_t;
  localparam int unsigned SCALE0_DEF = 25000000;
  localparam int unsigned SCALE1_DEF = 2500000;
  localparam int unsigned SCALE2_DEF = 250000;
  localparam int unsigned SCALE3_DEF = 25;
  localparam int unsigned DEB_DEF    = 500000;
endpackage

// File: rtl/clk_run_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stability counter; the level follows the input only
// after DEB_CYCLES consecutive samples that differ from the current level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic CCLK,
  input  logic rst_n,
  input  logic btn_i,
  output logic db_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d, diff, done;
  assign diff = sync_q[1] != db_q;
  assign done = cnt_q == CW'(DEB_CYCLES - 1);
  always_comb begin
    cnt_d = (diff && !done) ? cnt_q + 1'b1 : '0;
    db_d  = (diff && done) ? sync_q[1] : db_q;
  end
  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end
  assign db_o = db_q;
endmodule

// File: rtl/clk_run_ctrl.sv
// clk_run_ctrl: run/step/halt controller issuing a one-CCLK CPU clock enable from a
// speed-table divider, with debounced single-step and CPU-requested halt.
module clk_run_ctrl
  import clk_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEB_CYCLES = DEB_DEF,
  parameter int unsigned SCALE0     = SCALE0_DEF,
  parameter int unsigned SCALE1     = SCALE1_DEF,
  parameter int unsigned SCALE2     = SCALE2_DEF,
  parameter int unsigned SCALE3     = SCALE3_DEF
) (
  input  logic             CCLK,
  input  logic             rst_n,
  input  logic [1:0]       speed_sel,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic             cpu_clk,
  output logic [1:0]       mode,
  output logic             halted_hw,
  output logic [CNT_W-1:0] cur_scale,
  output logic [31:0]      cycle_cnt
);
  logic [1:0]       run_sync_q, sel1_q, sel_s_q;
  logic             db, db_prev_q, db_rise, run_s;
  mode_t            mode_q, mode_d;
  logic             halted_q, halted_d, ce_q, ce_d, clk_q, wrap;
  logic [CNT_W-1:0] cnt_q, cnt_d, scale_q, scale_d, p_m1, sel_scale;
  logic [31:0]      cyc_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_db (
    .CCLK  (CCLK),
    .rst_n (rst_n),
    .btn_i (step_btn),
    .db_o  (db)
  );

  assign run_s   = run_sync_q[1];
  assign db_rise = db && !db_prev_q;

  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      run_sync_q <= '0;
      sel1_q     <= '0;
      sel_s_q    <= '0;
      db_prev_q  <= 1'b0;
      mode_q     <= MODE_HALT;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
      scale_q    <= CNT_W'(SCALE0);
      ce_q       <= 1'b0;
      clk_q      <= 1'b0;
      cyc_q      <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], run_sw};
      sel1_q     <= speed_sel;
      sel_s_q    <= sel1_q;
      db_prev_q  <= db;
      mode_q     <= mode_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
      scale_q    <= scale_d;
      ce_q       <= ce_d;
      clk_q      <= clk_q ^ ce_d;
      cyc_q      <= cyc_q + {31'b0, ce_d};
    end
  end

  always_comb begin
    mode_d   = mode_q;
    halted_d = halted_q;
    if (halt_req) begin
      mode_d   = MODE_HALT;
      halted_d = 1'b1;
    end else begin
      case (mode_q)
        MODE_HALT:
          if (run_s && !halted_q) mode_d = MODE_RUN;
          else if (db_rise) mode_d = MODE_STEP;
          else if (!run_s) halted_d = 1'b0;
        MODE_RUN:  mode_d = run_s ? MODE_RUN : MODE_HALT;
        MODE_STEP: mode_d = MODE_WAIT_REL;
        default:   mode_d = db ? MODE_WAIT_REL : MODE_HALT;
      endcase
    end
  end

  // A scale of zero means period 1, so the terminal count is zero as well.
  always_comb begin
    sel_scale = sel_s_q == 2'd0 ? CNT_W'(SCALE0) :
                sel_s_q == 2'd1 ? CNT_W'(SCALE1) :
                sel_s_q == 2'd2 ? CNT_W'(SCALE2) : CNT_W'(SCALE3);
    p_m1      = (scale_q == '0) ? '0 : scale_q - CNT_W'(1);
    wrap      = mode_q == MODE_RUN && cnt_q == p_m1;
    ce_d      = wrap || mode_q == MODE_STEP;
    cnt_d     = (mode_q == MODE_RUN && mode_d == MODE_RUN && !wrap) ? cnt_q + CNT_W'(1) : '0;
    scale_d   = (wrap || mode_q != MODE_RUN) ? sel_scale : scale_q;
  end

  assign cpu_ce    = ce_q;
  assign cpu_clk   = clk_q;
  assign mode      = mode_q;
  assign halted_hw = halted_q;
  assign cur_scale = scale_q;
  assign cycle_cnt = cyc_q;
endmodule
